scale_mux_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one scale_mux datapath between two requesters (A, B).

---
 rtl/scale_mux_arbiter.sv | 115 +++++++++++
 tb/tb_scale_mux_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_mux_arbiter.sv
// Round-robin arbiter sharing one scale_mux datapath between requesters A and B,
// with bounded bursts and a valid/ready consumer port.

module scale_mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel_a,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out_data
);
  assign out_data = sel_a ? in_a : in_b;
endmodule

module scale_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] in_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] in_b,
  output logic             ack_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel_a,
  output logic             grant_a,
  output logic             grant_b
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t          state_q;
  state_t          other_state;
  logic [CW-1:0]   burst_cnt_q;
  logic            last_a_q;
  logic            req_own;
  logic            req_other;
  logic            xfer;

  assign grant_a     = (state_q == GNT_A);
  assign grant_b     = (state_q == GNT_B);
  assign sel_a       = grant_a;
  assign req_own     = grant_a ? req_a : req_b;
  assign req_other   = grant_a ? req_b : req_a;
  assign other_state = grant_a ? GNT_B : GNT_A;

  assign out_valid = (grant_a & req_a) | (grant_b & req_b);
  assign xfer      = out_valid & out_ready;
  assign ack_a     = xfer & grant_a;
  assign ack_b     = xfer & grant_b;

  scale_mux #(.WIDTH(WIDTH)) u_mux (
    .sel_a    (sel_a),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_data (out_data)
  );

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_a_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie the side not served last wins; last_a_q=0 favours A.
          if (req_a && (!req_b || !last_a_q)) begin
            state_q     <= GNT_A;
            last_a_q    <= 1'b1;
            burst_cnt_q <= '0;
          end else if (req_b) begin
            state_q     <= GNT_B;
            last_a_q    <= 1'b0;
            burst_cnt_q <= '0;
          end
        end
        GNT_A, GNT_B: begin
          if (xfer && (burst_cnt_q == CNT_LAST) && req_other) begin
            state_q     <= other_state;
            last_a_q    <= (other_state == GNT_A);
            burst_cnt_q <= '0;
          end else if (xfer) begin
            if (burst_cnt_q != CNT_LAST) burst_cnt_q <= burst_cnt_q + 1'b1;
          end else if (!req_own) begin
            burst_cnt_q <= '0;
            if (req_other) begin
              state_q  <= other_state;
              last_a_q <= (other_state == GNT_A);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scale_mux_arbiter.sv
// Self-checking bench for scale_mux_arbiter: directed vector table, corner-case
// sequences and randomized protocol-compliant traffic against a transaction-level model.

module tb_scale_mux_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         ack_a, ack_b, out_valid, sel_a, grant_a, grant_b;
  logic [W-1:0] out_data;

  // Second instance: MAX_BURST=1 under permanent contention.
  logic         r1_req = 1'b1, r1_ready = 1'b1;
  logic [W-1:0] r1_in_a = 8'hAA, r1_in_b = 8'hBB;
  logic         u1_ack_a, u1_ack_b, u1_valid, u1_sel_a, u1_grant_a, u1_grant_b;
  logic [W-1:0] u1_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: owner 0=none 1=A 2=B, transfers served in this grant.
  int m_owner  = 0;
  int m_served = 0;
  bit m_last_a = 1'b0;
  bit last_ack_a = 1'b0, last_ack_b = 1'b0;

  always #5 clk = ~clk;

  scale_mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .in_a(in_a), .ack_a(ack_a),
    .req_b(req_b), .in_b(in_b), .ack_b(ack_b),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel_a(sel_a), .grant_a(grant_a), .grant_b(grant_b)
  );

  scale_mux_arbiter #(.WIDTH(W), .MAX_BURST(1)) u1 (
    .clk(clk), .rst(rst),
    .req_a(r1_req), .in_a(r1_in_a), .ack_a(u1_ack_a),
    .req_b(r1_req), .in_b(r1_in_b), .ack_b(u1_ack_b),
    .out_valid(u1_valid), .out_data(u1_data), .out_ready(r1_ready),
    .sel_a(u1_sel_a), .grant_a(u1_grant_a), .grant_b(u1_grant_b)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observation vector: {grant_a, grant_b, sel_a, out_valid, ack_a, ack_b, out_data}
  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] obs();
    return {grant_a, grant_b, sel_a, out_valid, ack_a, ack_b, out_data};
  endfunction

  function automatic logic [13:0] model_obs();
    bit ga, gb, v, x;
    ga = (m_owner == 1);
    gb = (m_owner == 2);
    v  = (ga && req_a) || (gb && req_b);
    x  = v && out_ready;
    return {ga, gb, ga, v, x && ga, x && gb, ga ? in_a : in_b};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_served = 0; m_last_a = 1'b0;
    last_ack_a = 1'b0; last_ack_b = 1'b0;
  endtask

  task automatic hand_over();
    m_owner  = 3 - m_owner;
    m_served = 0;
    m_last_a = (m_owner == 1);
  endtask

  task automatic model_update(input logic ra, input logic rb, input logic rdy);
    bit ga, gb, x, mine, oth;
    ga = (m_owner == 1);
    gb = (m_owner == 2);
    x  = ((ga && ra) || (gb && rb)) && rdy;
    last_ack_a = x && ga;
    last_ack_b = x && gb;
    if (m_owner == 0) begin
      if (ra && rb)  m_owner = m_last_a ? 2 : 1;
      else if (ra)   m_owner = 1;
      else if (rb)   m_owner = 2;
      if (m_owner != 0) begin
        m_served = 0;
        m_last_a = (m_owner == 1);
      end
    end else begin
      mine = ga ? ra : rb;
      oth  = ga ? rb : ra;
      if (x) begin
        m_served++;
        if (m_served >= MB && oth) hand_over();
      end else if (!mine) begin
        if (oth) hand_over();
        else m_owner = 0;
      end
    end
  endtask

  // One clock: compare at negedge against the model, advance the model at posedge.
  task automatic step(input string name, output logic [13:0] got);
    logic ra, rb, rdy;
    @(negedge clk);
    got = obs();
    check({name, "/model"}, got, model_obs());
    ra = req_a; rb = req_b; rdy = out_ready;
    @(posedge clk);
    model_update(ra, rb, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic         ra;
    logic [W-1:0] da;
    logic         rb;
    logic [W-1:0] db;
    logic         rdy;
    logic [13:0]  exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [13:0] got;
    logic [1:0]  exp_ack;

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 8'h3C, 1'b1, {6'b000000, 8'h3C}};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 8'h3C, 1'b1, {6'b101110, 8'hA5}};
    vecs[2]  = '{1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0, {6'b101100, 8'h5A}};
    vecs[3]  = '{1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0, {6'b101100, 8'h5A}};
    vecs[4]  = '{1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0, {6'b101100, 8'h5A}};
    vecs[5]  = '{1'b1, 8'h5A, 1'b1, 8'h3C, 1'b1, {6'b101110, 8'h5A}};
    vecs[6]  = '{1'b1, 8'h5B, 1'b1, 8'h3C, 1'b1, {6'b101110, 8'h5B}};
    vecs[7]  = '{1'b1, 8'h5C, 1'b1, 8'h3C, 1'b1, {6'b101110, 8'h5C}};
    vecs[8]  = '{1'b1, 8'h5D, 1'b1, 8'h3C, 1'b1, {6'b010101, 8'h3C}};
    vecs[9]  = '{1'b1, 8'h5D, 1'b0, 8'h3C, 1'b1, {6'b010000, 8'h3C}};
    vecs[10] = '{1'b1, 8'h5D, 1'b0, 8'h3C, 1'b1, {6'b101110, 8'h5D}};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 14'h0000);
    rst = 1'b0;
    model_reset();

    // MAX_BURST=1: strict alternation A,B,A,B after one idle cycle
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_ack = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
      check("alt_burst1", {12'b0, u1_ack_a, u1_ack_b}, {12'b0, exp_ack});
      @(posedge clk);
      #1;
    end

    // Directed vector table: grant, backpressure, forced yield, empty handover cycle
    for (int i = 0; i < 11; i++) begin
      req_a = vecs[i].ra; in_a = vecs[i].da;
      req_b = vecs[i].rb; in_b = vecs[i].db;
      out_ready = vecs[i].rdy;
      step($sformatf("vec%0d", i), got);
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Both requesting: bursts of MB alternate between A and B
    req_a = 1'b0; req_b = 1'b0;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; in_a = 8'hA1; in_b = 8'hB1; out_ready = 1'b1;
    step("rr_idle", got);
    check("rr_idle", got, {6'b000000, 8'hB1});
    for (int k = 1; k <= 16; k++) begin
      step("rr", got);
      exp_ack = (((k - 1) / MB) % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("rr_ack%0d", k), {12'b0, got[9:8]}, {12'b0, exp_ack});
    end

    // Lone B requester: back-to-back transfers, grant never drops
    req_a = 1'b0; req_b = 1'b0;
    do_reset();
    req_b = 1'b1; in_b = 8'h4B;
    step("lone_idle", got);
    for (int k = 0; k < 10; k++) begin
      step("lone", got);
      check($sformatf("lone_b%0d", k), {12'b0, got[12], got[8]}, 14'b11);
    end

    // A drops after its last ack with B waiting: one empty cycle, then B
    req_b = 1'b0;
    do_reset();
    req_a = 1'b1; in_a = 8'h12; in_b = 8'h77;
    step("drop_idle", got);
    step("drop_ack_a", got);
    check("drop_ack_a", got, {6'b101110, 8'h12});
    req_a = 1'b0; req_b = 1'b1;
    step("drop_bubble", got);
    check("drop_bubble", got, {6'b101000, 8'h12});
    step("drop_gnt_b", got);
    check("drop_gnt_b", got, {6'b010101, 8'h77});

    // Reset mid-burst (cnt=2): outputs clear immediately, tie then goes to A
    req_b = 1'b0;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; in_a = 8'hC1; in_b = 8'hD2;
    step("mid_idle", got);
    step("mid_a0", got);
    step("mid_a1", got);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", obs(), {6'b000000, 8'hD2});
    #1;
    rst = 1'b0;
    model_reset();
    step("post_reset_idle", got);
    check("post_reset_idle", got, {6'b000000, 8'hD2});
    step("post_reset_tie", got);
    check("post_reset_tie", got, {6'b101110, 8'hC1});

    // Randomized protocol-compliant traffic
    req_a = 1'b0; req_b = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (last_ack_a) begin
        req_a = ($urandom_range(0, 3) != 0);
        in_a  = 8'($urandom);
      end else if (!req_a) begin
        req_a = 1'($urandom_range(0, 1));
        in_a  = 8'($urandom);
      end
      if (last_ack_b) begin
        req_b = ($urandom_range(0, 3) != 0);
        in_b  = 8'($urandom);
      end else if (!req_b) begin
        req_b = 1'($urandom_range(0, 1));
        in_b  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand", got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
